pos_gate_monitor: RTL and testbench



---
 rtl/pos_gate_pkg.sv | 27 ++
 rtl/pos_gate_monitor_if.sv | 12 +
 rtl/pos_gate_monitor_sat_counter.sv | 27 ++
 rtl/pos_gate_monitor.sv | 133 +++++++++++++
 tb/tb_pos_gate_monitor.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pos_gate_pkg.sv
// Shared definitions for the positive-gate monitor: FSM states, default widths
// and the reference max(a, 0) model reused by other gate checkers.
package pos_gate_pkg;

  localparam int unsigned DEF_W     = 3;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned EXP_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } mon_state_e;

  // Signed max with zero on a zero-extended sample whose sign sits at sign_pos.
  function automatic logic [EXP_MAX_W-1:0] pos_gate_exp(input logic [EXP_MAX_W-1:0] a,
                                                       input logic [4:0]           sign_pos);
    logic [EXP_MAX_W-1:0] res;
    if (a[sign_pos]) begin
      res = {EXP_MAX_W{1'b0}};
    end else begin
      res = a;
    end
    return res;
  endfunction

endpackage

// File: rtl/pos_gate_monitor_if.sv
// Sample-pair stream between the gate stimulus side (master) and the monitor (slave).
interface pos_gate_monitor_if #(
  parameter int unsigned W = 3
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_a;
  logic signed [W-1:0] in_out;

  modport master (output in_valid, output in_a, output in_out, input in_ready);
  modport slave  (input in_valid, input in_a, input in_out, output in_ready);
endinterface

// File: rtl/pos_gate_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins over increment, increment stops at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pos_gate_monitor.sv
// Response monitor for posGate: checks out == max(a, 0) per accepted pair and keeps counters.
// Optional first-mismatch capture ports err_a/err_out under POS_MON_FIRST_ERR_CAPTURE_EN.
module pos_gate_monitor
  import pos_gate_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  pos_gate_monitor_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                err,
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
  output logic [W-1:0]        err_a,
  output logic [W-1:0]        err_out,
`endif
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [CNT_W-1:0]    neg_cnt,
  output logic [CNT_W-1:0]    mismatch_cnt
);

  mon_state_e           state_r;
  mon_state_e           state_next_s;
  logic                 done_r;
  logic                 err_r;
  logic                 stage_valid_r;
  logic [W-1:0]         stage_a_r;
  logic [W-1:0]         stage_out_r;
  logic                 accept_s;
  logic                 clear_s;
  logic                 neg_s;
  logic                 mism_s;
  logic [EXP_MAX_W-1:0] exp_s;

  assign accept_s = bus.in_valid & (state_r == ST_RUN);
  assign clear_s  = start & (state_r == ST_IDLE);

  // Compare on zero-extended values so no bits of the reference result go unused.
  assign exp_s  = pos_gate_exp({{(EXP_MAX_W-W){1'b0}}, stage_a_r}, 5'(W-1));
  assign neg_s  = stage_valid_r & stage_a_r[W-1];
  assign mism_s = stage_valid_r & (exp_s != {{(EXP_MAX_W-W){1'b0}}, stage_out_r});

  // Next-state decode; start beats stop in IDLE, FLUSH always lasts one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_next_s = ST_FLUSH;
        else      state_next_s = ST_RUN;
      end
      ST_FLUSH: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State, done pulse and single-entry compare stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      done_r        <= 1'b0;
      stage_valid_r <= 1'b0;
      stage_a_r     <= {W{1'b0}};
      stage_out_r   <= {W{1'b0}};
    end else begin
      state_r       <= state_next_s;
      done_r        <= (state_r == ST_FLUSH);
      stage_valid_r <= accept_s;
      if (accept_s) begin
        stage_a_r   <= bus.in_a;
        stage_out_r <= bus.in_out;
      end
    end
  end

  // Sticky error flag, cleared only by start from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (clear_s) begin
      err_r <= 1'b0;
    end else if (mism_s) begin
      err_r <= 1'b1;
    end
  end

`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
  logic [W-1:0] err_a_r;
  logic [W-1:0] err_out_r;

  // Latch only the first mismatching pair of a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_a_r   <= {W{1'b0}};
      err_out_r <= {W{1'b0}};
    end else if (clear_s) begin
      err_a_r   <= {W{1'b0}};
      err_out_r <= {W{1'b0}};
    end else if (mism_s && !err_r) begin
      err_a_r   <= stage_a_r;
      err_out_r <= stage_out_r;
    end
  end

  assign err_a   = err_a_r;
  assign err_out = err_out_r;
`endif

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk (clk), .rst (rst), .clr (clear_s), .en (stage_valid_r), .cnt (sample_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_neg_cnt (
    .clk (clk), .rst (rst), .clr (clear_s), .en (neg_s), .cnt (neg_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk (clk), .rst (rst), .clr (clear_s), .en (mism_s), .cnt (mismatch_cnt)
  );

  assign bus.in_ready = (state_r == ST_RUN);
  assign busy         = (state_r != ST_IDLE);
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_pos_gate_monitor.sv
// Scoreboard bench for pos_gate_monitor: expected run totals are queued at stop
// and checked by an independent monitor whenever done pulses.
module tb_pos_gate_monitor;

  typedef struct {
    int samp;
    int neg;
    int mism;
    int err;
  } run_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic start2 = 1'b0;
  logic stop2 = 1'b0;
  logic busy, done, err, busy2, done2, err2;
  logic [7:0] sample_cnt, neg_cnt, mismatch_cnt;
  logic [1:0] sample_cnt2, neg_cnt2, mismatch_cnt2;
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
  logic signed [2:0] err_a, err_out, err_a2, err_out2;
`endif

  int tests = 0;
  int fails = 0;
  run_exp_t exp_q[$];

  // Bench-side reference counts for the current run of the main DUT.
  int m_samp, m_neg, m_mism, m_err;

  pos_gate_monitor_if #(.W(3)) bus ();
  pos_gate_monitor_if #(.W(3)) bus2 ();

  pos_gate_monitor #(.W(3), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .start (start), .stop (stop), .bus (bus),
    .busy (busy), .done (done), .err (err),
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
    .err_a (err_a), .err_out (err_out),
`endif
    .sample_cnt (sample_cnt), .neg_cnt (neg_cnt), .mismatch_cnt (mismatch_cnt)
  );

  pos_gate_monitor #(.W(3), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .start (start2), .stop (stop2), .bus (bus2),
    .busy (busy2), .done (done2), .err (err2),
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
    .err_a (err_a2), .err_out (err_out2),
`endif
    .sample_cnt (sample_cnt2), .neg_cnt (neg_cnt2), .mismatch_cnt (mismatch_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [2:0] ref_gate(input logic signed [2:0] a);
    return (a < 3'sd0) ? 3'sd0 : a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus on the main DUT; the model counts it if it is accepted.
  task automatic drive(input logic signed [2:0] a, input logic signed [2:0] o,
                       input bit v, input bit in_run);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_out   = o;
    tick();
    if (v && in_run) begin
      m_samp++;
      if (a < 3'sd0) m_neg++;
      if (o != ref_gate(a)) begin
        m_mism++;
        m_err = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_samp = 0; m_neg = 0; m_mism = 0; m_err = 0;
  endtask

  task automatic do_stop(input logic signed [2:0] a, input logic signed [2:0] o, input bit v);
    run_exp_t e;
    stop = 1'b1;
    drive(a, o, v, 1'b1);
    stop = 1'b0;
    e.samp = m_samp; e.neg = m_neg; e.mism = m_mism; e.err = m_err;
    exp_q.push_back(e);
    check("in_ready_after_stop", int'(bus.in_ready), 0);
  endtask

  // Scoreboard monitor: every done pulse retires one queued expectation.
  initial begin : monitor
    bit prev_done;
    run_exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_single_cycle", int'(prev_done), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_sample_cnt", int'(sample_cnt), e.samp);
          check("sb_neg_cnt", int'(neg_cnt), e.neg);
          check("sb_mismatch_cnt", int'(mismatch_cnt), e.mism);
          check("sb_err", int'(err), e.err);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_a = 3'sd0; bus.in_out = 3'sd0;
    bus2.in_valid = 1'b0; bus2.in_a = 3'sd0; bus2.in_out = 3'sd0;
    m_samp = 0; m_neg = 0; m_mism = 0; m_err = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_sample_cnt", int'(sample_cnt), 0);
    check("rst_neg_cnt", int'(neg_cnt), 0);
    check("rst_mismatch_cnt", int'(mismatch_cnt), 0);
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
    check("rst_err_a", int'(err_a), 0);
    check("rst_err_out", int'(err_out), 0);
`endif

    // Correct stream 0,-1,-2,3,-4
    do_start();
    check("run_busy", int'(busy), 1);
    check("run_in_ready", int'(bus.in_ready), 1);
    drive(3'sd0, 3'sd0, 1'b1, 1'b1);
    drive(-3'sd1, 3'sd0, 1'b1, 1'b1);
    drive(-3'sd2, 3'sd0, 1'b1, 1'b1);
    drive(3'sd3, 3'sd3, 1'b1, 1'b1);
    drive(-3'sd4, 3'sd0, 1'b1, 1'b1);
    do_stop(3'sd0, 3'sd0, 1'b0);
    repeat (3) tick();

    // Mismatch stream: -1/-1 then 3/2
    do_start();
    check("start_clears_cnt", int'(sample_cnt), 0);
    drive(-3'sd1, -3'sd1, 1'b1, 1'b1);
    drive(3'sd3, 3'sd2, 1'b1, 1'b1);
    check("err_after_first_bad", int'(err), 1);
    check("mism_after_first_bad", int'(mismatch_cnt), 1);
    drive(3'sd0, 3'sd0, 1'b0, 1'b1);
    check("mism_after_second_bad", int'(mismatch_cnt), 2);
`ifdef POS_MON_FIRST_ERR_CAPTURE_EN
    check("cap_err_a", int'(err_a), -1);
    check("cap_err_out", int'(err_out), -1);
`endif
    do_stop(3'sd0, 3'sd0, 1'b0);
    repeat (4) tick();
    check("idle_hold_sample_cnt", int'(sample_cnt), 2);
    check("idle_hold_err", int'(err), 1);

    // Random in_valid toggling over 20 cycles of correct pairs
    do_start();
    for (int i = 0; i < 20; i++) begin
      logic signed [2:0] ra;
      ra = 3'($urandom_range(0, 7));
      drive(ra, ref_gate(ra), 1'($urandom_range(0, 1)), 1'b1);
    end
    do_stop(3'sd0, 3'sd0, 1'b0);
    repeat (3) tick();

    // Start ignored in RUN; stop together with an accepted 3/3 sample
    do_start();
    drive(-3'sd3, 3'sd0, 1'b1, 1'b1);
    drive(3'sd1, 3'sd1, 1'b1, 1'b1);
    start = 1'b1;
    drive(3'sd0, 3'sd0, 1'b0, 1'b1);
    start = 1'b0;
    do_stop(3'sd3, 3'sd3, 1'b1);
    tick();
    check("done_after_stop_sample", int'(done), 1);
    check("final_sample_cnt", int'(sample_cnt), 3);
    repeat (2) tick();

    // start and stop together in IDLE: start wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    m_samp = 0; m_neg = 0; m_mism = 0; m_err = 0;
    check("start_stop_busy", int'(busy), 1);
    check("start_stop_in_ready", int'(bus.in_ready), 1);
    do_stop(3'sd0, 3'sd0, 1'b0);
    repeat (3) tick();

    // Reset mid-run: everything clears, no done
    do_start();
    drive(-3'sd1, 3'sd1, 1'b1, 1'b1);
    drive(3'sd2, 3'sd2, 1'b1, 1'b1);
    bus.in_valid = 1'b1; bus.in_a = -3'sd2; bus.in_out = 3'sd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_sample_cnt", int'(sample_cnt), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_mismatch_cnt", int'(mismatch_cnt), 0);
    repeat (3) tick();
    check("midrst_stage_discarded", int'(sample_cnt), 0);
    do_start();
    drive(-3'sd2, 3'sd0, 1'b1, 1'b1);
    do_stop(3'sd0, 3'sd0, 1'b0);
    repeat (3) tick();

    // CNT_W=2 instance: six negative samples saturate at 3
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_a     = -3'sd1;
      bus2.in_out   = 3'sd0;
      tick();
    end
    bus2.in_valid = 1'b0;
    stop2 = 1'b1;
    tick();
    stop2 = 1'b0;
    repeat (2) tick();
    check("sat_neg_cnt", int'(neg_cnt2), 3);
    check("sat_sample_cnt", int'(sample_cnt2), 3);
    check("sat_mismatch_cnt", int'(mismatch_cnt2), 0);

    check("missing_done", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
